// File: rtl/imem_loader_if.sv
// Byte-stream load handshake between the boot host and imem_loader.
// A byte transfers on a rising edge where ld_valid and ld_ready are both high.
interface imem_loader_if;
    logic [7:0] ld_data;
    logic       ld_valid;
    logic       ld_ready;

    modport master (output ld_data, output ld_valid, input ld_ready);
    modport slave  (input ld_data, input ld_valid, output ld_ready);
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction RAM and loader: receives length, little-endian words and
// an XOR checksum, then releases the core from reset and serves fetches combinationally.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// LEN_LO   | waiting for word-count low byte
// LEN_HI   | waiting for word-count high byte
// DATA     | assembling 32-bit words, 4 bytes each, into RAM
// CSUM     | waiting for XOR checksum byte
// RUN      | load good, core released (terminal until rst)
// ERROR    | checksum mismatch or RAM overflow (terminal until rst)
module imem_loader #(
    parameter int i_addr_bits = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    imem_loader_if.slave           ld,
    input  logic [i_addr_bits-1:0] i_mem_addr,
    output logic [31:0]            i_mem_data,
    output logic                   core_rst_n,
    output logic                   done,
    output logic                   error,
    output logic [15:0]            words_loaded
);

    localparam int DEPTH = 1 << i_addr_bits;

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_ERROR
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_len;
    logic [1:0]  r_byte_cnt;
    logic [23:0] r_word_buf;
    logic [7:0]  r_csum;
    logic        r_overflow;
    logic [15:0] r_words_loaded;
    logic        r_done;
    logic        r_error;
    logic        r_core_rst_n;
    logic [31:0] r_mem [0:DEPTH-1];

    logic        w_ready;
    logic        w_xfer;
    logic        w_word_done;
    logic        w_room;
    logic        w_mem_we;
    logic [15:0] w_wl_inc;

    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM: w_ready = 1'b1;
            default:                            w_ready = 1'b0;
        endcase
    end

    assign ld.ld_ready  = w_ready;
    assign w_xfer       = ld.ld_valid & w_ready;
    assign w_word_done  = w_xfer && (r_state == S_DATA) && (r_byte_cnt == 2'd3);
    assign w_room       = ({16'd0, r_words_loaded} < 32'(DEPTH));
    assign w_mem_we     = w_word_done && w_room && !rst;
    assign w_wl_inc     = r_words_loaded + 16'd1;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LEN_LO: if (w_xfer) w_state_nxt = S_LEN_HI;
            S_LEN_HI: if (w_xfer) w_state_nxt = ({ld.ld_data, r_len[7:0]} != 16'd0) ? S_DATA : S_CSUM;
            S_DATA:   if (w_word_done && (w_wl_inc == r_len)) w_state_nxt = S_CSUM;
            S_CSUM:   if (w_xfer) w_state_nxt = ((ld.ld_data == r_csum) && !r_overflow) ? S_RUN : S_ERROR;
            S_RUN:    w_state_nxt = S_RUN;
            S_ERROR:  w_state_nxt = S_ERROR;
            default:  w_state_nxt = S_LEN_LO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_LEN_LO;
            r_len          <= 16'd0;
            r_byte_cnt     <= 2'd0;
            r_word_buf     <= 24'd0;
            r_csum         <= 8'd0;
            r_overflow     <= 1'b0;
            r_words_loaded <= 16'd0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            r_core_rst_n   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_done       <= (w_state_nxt == S_RUN);
            r_error      <= (w_state_nxt == S_ERROR);
            r_core_rst_n <= (w_state_nxt == S_RUN);
            if (w_xfer && (r_state != S_CSUM))
                r_csum <= r_csum ^ ld.ld_data;
            if (w_xfer && (r_state == S_LEN_LO))
                r_len[7:0] <= ld.ld_data;
            if (w_xfer && (r_state == S_LEN_HI))
                r_len[15:8] <= ld.ld_data;
            if (w_xfer && (r_state == S_DATA)) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
                case (r_byte_cnt)
                    2'd0:    r_word_buf[7:0]   <= ld.ld_data;
                    2'd1:    r_word_buf[15:8]  <= ld.ld_data;
                    2'd2:    r_word_buf[23:16] <= ld.ld_data;
                    default: r_word_buf        <= r_word_buf;
                endcase
            end
            // Words beyond RAM depth are still counted so the host sees how many it sent.
            if (w_word_done) begin
                if (!w_room)
                    r_overflow <= 1'b1;
                if (r_words_loaded != 16'hFFFF)
                    r_words_loaded <= w_wl_inc;
            end
        end
    end

    // RAM has no reset so a prior image survives an aborted reload.
    always_ff @(posedge clk) begin
        if (w_mem_we)
            r_mem[r_words_loaded[i_addr_bits-1:0]] <= {ld.ld_data, r_word_buf};
    end

    assign i_mem_data   = r_mem[i_mem_addr];
    assign core_rst_n   = r_core_rst_n;
    assign done         = r_done;
    assign error        = r_error;
    assign words_loaded = r_words_loaded;

endmodule
